// File: rtl/edge_det_pkg.sv
// Shared constants and helpers for the switch-input conditioner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package edge_det_pkg;

    // Values accepted by the EDGE_MODE parameter.
    localparam int EDGE_FALL = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_BOTH = 2;

    // Number of bits needed to hold every value in 0..max_val, never less than 1.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/edge_det_db_ch.sv
// One switch channel: synchroniser, debounce filter, edge strobe and long-press strobe.
// Latency: det/level update SYNC_STAGES+DB_CYCLES edges after sw is first sampled; long_det LONG_CYCLES edges after that.
// Backpressure: none; outputs are free-running single-cycle strobes.
//
// Ports:
//   mclk     - system clock, all state on posedge
//   rst      - synchronous active-high reset
//   sw       - raw asynchronous switch input
//   level    - debounced stable level
//   det      - one-cycle strobe on an accepted level change matching EDGE_MODE
//   long_det - one-cycle strobe when a press has lasted LONG_CYCLES cycles
module edge_det_db_ch
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int EDGE_MODE   = EDGE_FALL,
    parameter bit PRESS_LEVEL = 1'b1,
    parameter int LONG_CYCLES = 8
) (
    input  logic mclk,
    input  logic rst,
    input  logic sw,
    output logic level,
    output logic det,
    output logic long_det
);

    localparam int              DB_W     = cnt_width(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic            IDLE_LVL = ~PRESS_LEVEL;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_W-1:0]        r_db_cnt;
    logic                   r_level;
    logic                   r_det;

    logic w_s;
    logic w_diff;
    logic w_update;
    logic w_edge_hit;

    assign w_s = r_sync[SYNC_STAGES-1];

    // A level change is accepted on the edge where the differing sample has
    // already been seen DB_CYCLES-1 times and is still differing now.
    always_comb begin
        w_diff     = w_s ^ r_level;
        w_update   = w_diff && (r_db_cnt == DB_LAST);
        w_edge_hit = 1'b0;
        case (EDGE_MODE)
            EDGE_FALL: w_edge_hit = w_update && !w_s;
            EDGE_RISE: w_edge_hit = w_update &&  w_s;
            default:   w_edge_hit = w_update;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_sync   <= {SYNC_STAGES{IDLE_LVL}};
            r_db_cnt <= '0;
            r_level  <= IDLE_LVL;
            r_det    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sw};
            // Counter is cleared on acceptance, so it tops out at DB_LAST and
            // can never wrap.
            if (w_update) begin
                r_level  <= w_s;
                r_db_cnt <= '0;
            end else if (w_diff) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end else begin
                r_db_cnt <= '0;
            end
            r_det <= w_edge_hit;
        end
    end

    assign level = r_level;
    assign det   = r_det;

    generate
        if (LONG_CYCLES > 0) begin : g_long
            localparam int              LP_W    = cnt_width(LONG_CYCLES);
            localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_CYCLES);
            localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_CYCLES - 1);

            logic [LP_W-1:0] r_lp_cnt;
            logic            r_long;
            logic            w_held;

            // Leaving the pressed level clears the count on the same edge the
            // debounced level changes, so a release always re-arms.
            assign w_held = (r_level == PRESS_LEVEL) && !w_update;

            always_ff @(posedge mclk) begin
                if (rst) begin
                    r_lp_cnt <= '0;
                    r_long   <= 1'b0;
                end else if (!w_held) begin
                    r_lp_cnt <= '0;
                    r_long   <= 1'b0;
                end else if (r_lp_cnt != LP_MAX) begin
                    r_lp_cnt <= r_lp_cnt + 1'b1;
                    r_long   <= (r_lp_cnt == LP_LAST);
                end else begin
                    // Saturated: hold silently until the press ends.
                    r_long   <= 1'b0;
                end
            end

            assign long_det = r_long;
        end else begin : g_no_long
            assign long_det = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/edge_det_db.sv
// N-channel switch input conditioner producing clean mclk-domain level, edge and long-press strobes.
// Latency: SYNC_STAGES+DB_CYCLES edges from first sampling of a clean transition to level/det.
// Backpressure: none; channels are independent and strobes are single-cycle.
//
// Ports:
//   mclk     - system clock, all state on posedge
//   rst      - synchronous active-high reset
//   sw       - N_CH raw asynchronous switch inputs
//   level    - N_CH debounced levels
//   det      - N_CH one-cycle edge strobes selected by EDGE_MODE
//   long_det - N_CH one-cycle long-press strobes (tied low when LONG_CYCLES is 0)
module edge_det_db
    import edge_det_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int EDGE_MODE   = EDGE_FALL,
    parameter bit PRESS_LEVEL = 1'b1,
    parameter int LONG_CYCLES = 8
) (
    input  logic            mclk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] det,
    output logic [N_CH-1:0] long_det
);

    // Channels share nothing but clock and reset.
    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            edge_det_db_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .DB_CYCLES   (DB_CYCLES),
                .EDGE_MODE   (EDGE_MODE),
                .PRESS_LEVEL (PRESS_LEVEL),
                .LONG_CYCLES (LONG_CYCLES)
            ) u_ch (
                .mclk     (mclk),
                .rst      (rst),
                .sw       (sw[i]),
                .level    (level[i]),
                .det      (det[i]),
                .long_det (long_det[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_edge_det_db.sv
module tb_edge_det_db;

    logic       mclk = 1'b0;
    logic       rst  = 1'b1;
    logic [2:0] sw   = 3'b000;

    logic [2:0] level_f, det_f, long_f;   // EDGE_MODE=0 instance
    logic [2:0] level_b, det_b, long_b;   // EDGE_MODE=2 instance

    int checks = 0;
    int errors = 0;

    always #5 mclk = ~mclk;

    edge_det_db #(
        .N_CH(3), .SYNC_STAGES(2), .DB_CYCLES(4), .EDGE_MODE(0),
        .PRESS_LEVEL(1'b1), .LONG_CYCLES(8)
    ) dut_fall (
        .mclk(mclk), .rst(rst), .sw(sw),
        .level(level_f), .det(det_f), .long_det(long_f)
    );

    edge_det_db #(
        .N_CH(3), .SYNC_STAGES(2), .DB_CYCLES(4), .EDGE_MODE(2),
        .PRESS_LEVEL(1'b1), .LONG_CYCLES(8)
    ) dut_both (
        .mclk(mclk), .rst(rst), .sw(sw),
        .level(level_b), .det(det_b), .long_det(long_b)
    );

    typedef struct {
        string      tag;
        logic [2:0] sw;
        int         n;      // cycles to hold sw; expectations apply to each
        logic [2:0] lvl;
        logic [2:0] det;    // falling-edge instance
        logic [2:0] lng;
        logic [2:0] det2;   // both-edges instance
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string tag, input logic [2:0] s, input int n,
                       input logic [2:0] el, input logic [2:0] ed,
                       input logic [2:0] elg, input logic [2:0] ed2);
        vec_t v;
        v.tag = tag; v.sw = s; v.n = n;
        v.lvl = el; v.det = ed; v.lng = elg; v.det2 = ed2;
        tbl.push_back(v);
    endtask

    // Drive sw, then for each of n edges sample #1 after posedge and compare.
    task automatic run_row(input string tag, input logic [2:0] s, input int n,
                           input logic [2:0] el, input logic [2:0] ed,
                           input logic [2:0] elg, input logic [2:0] ed2);
        logic [17:0] got;
        logic [17:0] exp;
        sw = s;
        for (int c = 0; c < n; c++) begin
            @(posedge mclk);
            #1;
            checks++;
            got = {level_f, det_f, long_f, level_b, det_b, long_b};
            exp = {el, ed, elg, el, ed2, elg};
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cyc%0d: got lvl=%b det=%b long=%b | both lvl=%b det=%b long=%b ; want lvl=%b det=%b long=%b | det_both=%b",
                         tag, c, level_f, det_f, long_f, level_b, det_b, long_b, el, ed, elg, ed2);
            end
        end
    endtask

    initial begin
        // Press/release on ch0 held 30 cycles; run twice to show re-arm.
        for (int r = 0; r < 2; r++) begin
            add("press_wait",    3'b001,  5, 3'b000, 3'b000, 3'b000, 3'b000);
            add("press_accept",  3'b001,  1, 3'b001, 3'b000, 3'b000, 3'b001);
            add("press_count",   3'b001,  7, 3'b001, 3'b000, 3'b000, 3'b000);
            add("long_fire",     3'b001,  1, 3'b001, 3'b000, 3'b001, 3'b000);
            add("long_norepeat", 3'b001, 16, 3'b001, 3'b000, 3'b000, 3'b000);
            add("release_wait",  3'b000,  5, 3'b001, 3'b000, 3'b000, 3'b000);
            add("release_det",   3'b000,  1, 3'b000, 3'b001, 3'b000, 3'b001);
            add("release_idle",  3'b000,  3, 3'b000, 3'b000, 3'b000, 3'b000);
        end
        // 3-cycle glitch on ch1 is rejected.
        add("glitch3",       3'b010,  3, 3'b000, 3'b000, 3'b000, 3'b000);
        add("glitch3_after", 3'b000, 10, 3'b000, 3'b000, 3'b000, 3'b000);
        // 4-cycle pulse on ch1 is exactly long enough to be accepted.
        add("pulse4",        3'b010,  4, 3'b000, 3'b000, 3'b000, 3'b000);
        add("pulse4_wait",   3'b000,  1, 3'b000, 3'b000, 3'b000, 3'b000);
        add("pulse4_rise",   3'b000,  1, 3'b010, 3'b000, 3'b000, 3'b010);
        add("pulse4_high",   3'b000,  3, 3'b010, 3'b000, 3'b000, 3'b000);
        add("pulse4_fall",   3'b000,  1, 3'b000, 3'b010, 3'b000, 3'b010);
        add("pulse4_idle",   3'b000,  3, 3'b000, 3'b000, 3'b000, 3'b000);
        // Bounce 1,0,1,0,1 then hold on ch2.
        add("bounce_a",      3'b100,  1, 3'b000, 3'b000, 3'b000, 3'b000);
        add("bounce_b",      3'b000,  1, 3'b000, 3'b000, 3'b000, 3'b000);
        add("bounce_c",      3'b100,  1, 3'b000, 3'b000, 3'b000, 3'b000);
        add("bounce_d",      3'b000,  1, 3'b000, 3'b000, 3'b000, 3'b000);
        add("bounce_settle", 3'b100,  5, 3'b000, 3'b000, 3'b000, 3'b000);
        add("bounce_rise",   3'b100,  1, 3'b100, 3'b000, 3'b000, 3'b100);
        add("bounce_hold",   3'b100,  4, 3'b100, 3'b000, 3'b000, 3'b000);
        add("bounce_rel",    3'b000,  3, 3'b100, 3'b000, 3'b000, 3'b000);
        add("bounce_long",   3'b000,  1, 3'b100, 3'b000, 3'b100, 3'b000);
        add("bounce_rel2",   3'b000,  1, 3'b100, 3'b000, 3'b000, 3'b000);
        add("bounce_fall",   3'b000,  1, 3'b000, 3'b100, 3'b000, 3'b100);
        add("bounce_idle",   3'b000,  3, 3'b000, 3'b000, 3'b000, 3'b000);
        // Simultaneous press and release on all channels.
        add("all_wait",      3'b111,  5, 3'b000, 3'b000, 3'b000, 3'b000);
        add("all_press",     3'b111,  1, 3'b111, 3'b000, 3'b000, 3'b111);
        add("all_count",     3'b111,  7, 3'b111, 3'b000, 3'b000, 3'b000);
        add("all_long",      3'b111,  1, 3'b111, 3'b000, 3'b111, 3'b000);
        add("all_hold",      3'b111,  2, 3'b111, 3'b000, 3'b000, 3'b000);
        add("all_relwait",   3'b000,  5, 3'b111, 3'b000, 3'b000, 3'b000);
        add("all_release",   3'b000,  1, 3'b000, 3'b111, 3'b000, 3'b111);
        add("all_idle",      3'b000,  3, 3'b000, 3'b000, 3'b000, 3'b000);

        // Reset state.
        rst = 1'b1;
        run_row("reset_state", 3'b000, 3, 3'b000, 3'b000, 3'b000, 3'b000);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            run_row(tbl[i].tag, tbl[i].sw, tbl[i].n,
                    tbl[i].lvl, tbl[i].det, tbl[i].lng, tbl[i].det2);

        // Reset for 2 cycles while ch0 debounce count is 2; sw stays high.
        run_row("rst_pre",      3'b001, 4, 3'b000, 3'b000, 3'b000, 3'b000);
        rst = 1'b1;
        run_row("rst_mid",      3'b001, 2, 3'b000, 3'b000, 3'b000, 3'b000);
        rst = 1'b0;
        run_row("rst_restart",  3'b001, 5, 3'b000, 3'b000, 3'b000, 3'b000);
        run_row("rst_accept",   3'b001, 1, 3'b001, 3'b000, 3'b000, 3'b001);
        run_row("rst_relwait",  3'b000, 5, 3'b001, 3'b000, 3'b000, 3'b000);
        run_row("rst_release",  3'b000, 1, 3'b000, 3'b001, 3'b000, 3'b001);
        run_row("rst_idle",     3'b000, 3, 3'b000, 3'b000, 3'b000, 3'b000);

        // Switches held through reset: press edge appears after release of reset.
        rst = 1'b1;
        run_row("pwr_in_rst",   3'b111, 2, 3'b000, 3'b000, 3'b000, 3'b000);
        rst = 1'b0;
        run_row("pwr_wait",     3'b111, 5, 3'b000, 3'b000, 3'b000, 3'b000);
        run_row("pwr_press",    3'b111, 1, 3'b111, 3'b000, 3'b000, 3'b111);
        run_row("pwr_count",    3'b111, 7, 3'b111, 3'b000, 3'b000, 3'b000);
        run_row("pwr_long",     3'b111, 1, 3'b111, 3'b000, 3'b111, 3'b000);
        run_row("pwr_relwait",  3'b000, 5, 3'b111, 3'b000, 3'b000, 3'b000);
        run_row("pwr_release",  3'b000, 1, 3'b000, 3'b111, 3'b000, 3'b111);
        run_row("pwr_idle",     3'b000, 3, 3'b000, 3'b000, 3'b000, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_det_db.md
Name: edge_det_db

Overview:
Parametrised N-channel switch input conditioner and successor to the 3-channel edge detector.
- Per channel: multi-stage synchroniser, then debounce filter, then registered edge pulse with selectable polarity, plus a long-press pulse.
- Sits between the raw board switches and the stopwatch control FSM. Delivers clean single-cycle strobes in the mclk domain.

Parameters:
N_CH, 3, number of independent switch channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DB_CYCLES, 4, consecutive mclk cycles a new level must persist before acceptance (>=1)
EDGE_MODE, 0, 0 = falling, 1 = rising, 2 = both edges of the debounced level generate det
PRESS_LEVEL, 1, debounced level treated as "pressed" for long-press timing
LONG_CYCLES, 8, cycles pressed before long_det fires; 0 disables long_det

Ports:
mclk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
sw  in  N_CH  raw asynchronous switch inputs
level  out  N_CH  debounced stable level per channel
det  out  N_CH  one-cycle edge strobe per channel, per EDGE_MODE
long_det  out  N_CH  one-cycle strobe when a press reaches LONG_CYCLES

Behaviour:
- Interface: one clock, mclk. Reset is synchronous and active-high on rst. All state is sampled on the mclk posedge with rst high.
- Reset values:
  - synchroniser flops = ~PRESS_LEVEL
  - level = ~PRESS_LEVEL
  - debounce counters = 0
  - long counters = 0
  - det = 0, long_det = 0
- Reset mid-operation aborts any pending debounce or long count. No strobe is emitted in the first cycle after rst deasserts.
- Synchroniser: sw[i] passes through SYNC_STAGES flops. The last stage is s[i].
- Debounce, per channel:
  - If s != level: db_cnt increments.
  - When db_cnt == DB_CYCLES-1 and s != level on the same edge: level <= s and db_cnt <= 0.
  - If s == level: db_cnt <= 0. Glitches shorter than DB_CYCLES consecutive cycles are fully rejected.
  - Counter width is clog2(DB_CYCLES+1). It never wraps.
- Edge strobe:
  - det[i] is registered and asserts on the same edge that level[i] updates. It is high for exactly one cycle.
  - The update must match EDGE_MODE: 0 = level 1->0, 1 = level 0->1, 2 = any change.
  - Latency: a clean sw transition produces det exactly SYNC_STAGES+DB_CYCLES mclk edges after the first edge that samples the new value.
- Long press:
  - lp_cnt counts while level == PRESS_LEVEL and saturates at LONG_CYCLES.
  - long_det pulses once, for one cycle, on the edge where lp_cnt reaches LONG_CYCLES.
  - lp_cnt clears to 0 on the edge where level leaves PRESS_LEVEL.
  - No repeat while the switch stays held. A new press is required to re-arm.
  - LONG_CYCLES = 0: long_det is tied 0 and the counter is optimised away.
- Channel independence: channels share no state. Simultaneous events on several channels produce simultaneous strobes.
- Power-up with switch held: because level resets to idle, a channel held pressed through reset generates a press edge after SYNC_STAGES+DB_CYCLES cycles. That edge fires det if EDGE_MODE matches, and the long press then times normally.

Decomposition:
- Shared package edge_det_pkg holds:
  - localparams EDGE_FALL=0, EDGE_RISE=1, EDGE_BOTH=2
  - a clog2-based width helper function
- One per-channel sub-module, edge_det_db_ch, contains the synchroniser, debounce counter, edge logic and long-press counter. The top level instantiates it N_CH times in a generate loop.

Test Plan (N_CH=3, SYNC_STAGES=2, DB_CYCLES=4, LONG_CYCLES=8, PRESS_LEVEL=1, EDGE_MODE=0 unless stated):
- Clean press and release on sw[0] (0->1, held 20 cycles, 1->0):
  - level[0] rises 6 edges after the first sampling edge
  - det[0] fires one cycle on release, 6 edges after the release is sampled
  - no det on press
- Glitch: sw[1] high for 3 cycles, then low -> level[1] stays 0; det and long_det stay 0 throughout.
- Bounce: sw[2] toggles 1,0,1,0,1 each cycle, then holds 1 -> level[2] rises only 4 stable cycles after the final edge reaches s, and exactly once.
- Long press: sw[0] held 1 for 30 cycles -> long_det[0] fires exactly once, 8 cycles after level[0] rises. On release and re-press the counter re-arms and fires again.
- EDGE_MODE=2 with simultaneous press on all 3 channels -> det = 3'b111 for one cycle on press and again on release.
- rst asserted for 2 cycles while db_cnt = 2 mid-debounce -> no strobe. level returns to 0, and if sw is still high, debounce restarts from 0 after reset.
